fifo_param: RTL and testbench
=============================

# fifo_param

Parametrised synchronous FIFO on a valid/ready stream. It is the general-purpose buffer between stdio-style producers and consumers: CPU console, front-panel and serial adapters. It extends the basic 16-bit FIFO with:
- configurable data width;
- any depth ≥ 2, with all DEPTH entries usable;
- occupancy and almost-full/almost-empty flags;
- synchronous flush;
- optional fall-through (zero-latency) mode.

## Interface
Parameters:
- WIDTH, 16, data word width in bits (≥1).
- DEPTH, 4, number of storage entries (≥2, need not be a power of two).
- AF_LEVEL, DEPTH-1, almost_full_o asserts when count ≥ AF_LEVEL (legal 1..DEPTH).
- AE_LEVEL, 1, almost_empty_o asserts when count ≤ AE_LEVEL (legal 0..DEPTH-1).
- FALLTHROUGH, 0, 1 = an empty FIFO forwards input to output in the same cycle.
- Derived: CW = $clog2(DEPTH+1), the count width.
- Illegal parameter values are rejected by elaboration-time assertions.

Ports:
- Clock and reset: one clock, clk_i; reset rst_ni is asynchronous and active-low.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of all contents.
- in_val_i  in  1  producer has a word.
- in_rdy_o  out  1  FIFO accepts a word this cycle.
- in_data_i  in  WIDTH  write data.
- out_val_o  out  1  a word is available.
- out_rdy_i  in  1  consumer takes the word.
- out_data_o  out  WIDTH  head-of-queue data.
- count_o  out  CW  current occupancy, 0..DEPTH.
- full_o  out  1  count_o == DEPTH.
- empty_o  out  1  count_o == 0.
- almost_full_o  out  1  count_o ≥ AF_LEVEL.
- almost_empty_o  out  1  count_o ≤ AE_LEVEL.

## Operation
- Storage: DEPTH × WIDTH array, not reset.
- Pointers rptr and wptr are each $clog2(DEPTH) bits. Each advances by 1 and wraps explicitly from DEPTH-1 to 0; no reliance on power-of-two modulo.
- Occupancy is held in a registered counter `count`, CW bits.
- Push: `in_val_i && in_rdy_o`. The write goes to mem[wptr], then wptr advances.
- Pop: `out_val_o && out_rdy_i`. rptr advances.
- Count update:
  - push only: +1;
  - pop only: −1;
  - both, or neither: unchanged.
- in_rdy_o = !flush_i && (count != DEPTH). It never depends on out_rdy_i, so there is no ready-through path. When full, a simultaneous pop does not enable a push that cycle.
- out_val_o = !flush_i && (count != 0). out_data_o = mem[rptr].
- FALLTHROUGH=1 with count == 0 and !flush_i:
  - out_val_o = in_val_i and out_data_o = in_data_i, both combinational.
  - If out_rdy_i is also high, the word bypasses storage. Pointers and count are unchanged, and the transfer counts as both push and pop.
  - If out_rdy_i is low, the word is stored normally.
- Flush:
  - Highest priority. During the flush cycle in_rdy_o = 0 and out_val_o = 0, so no transfer occurs.
  - On the next edge rptr, wptr and count all go to 0.
- Status flags are pure functions of registered count, so they are glitch-free relative to the handshake inputs.
- out_data_o is don't-care whenever out_val_o = 0.

## Timing
- Reset (async assert, sync-style release on clk_i) sets rptr = wptr = 0 and count = 0. Output values:
  - in_rdy_o = 1 (when flush_i = 0);
  - out_val_o = 0 (FALLTHROUGH=1: follows in_val_i);
  - count_o = 0, empty_o = 1, full_o = 0;
  - almost_empty_o = 1;
  - almost_full_o = 0.
- Reset mid-operation discards all contents immediately, without waiting for a clock edge.
- Latency, FALLTHROUGH=0: a word pushed at edge n is visible (out_val_o = 1) in the cycle after edge n.
- Latency, FALLTHROUGH=1, empty FIFO: 0 cycles.
- Throughput: one push and one pop per cycle when 0 < count < DEPTH.
- In the full state the sustained rate is one word per cycle only if the consumer pops every cycle. One bubble on the input side follows each full cycle.
- Wrap-around: pointers pass DEPTH-1 → 0 with no lost or duplicated word. For odd DEPTH (e.g. 3), the pointer never reaches the value DEPTH.
- Flush and push/pop requests in the same cycle: only the flush takes effect.

## Test plan
- Reset, then idle: count_o = 0, empty_o = 1, in_rdy_o = 1, out_val_o = 0. Assert rst_ni low mid-stream with 3 words queued: count_o = 0 immediately, out_val_o = 0.
- DEPTH=5, WIDTH=8, out_rdy_i = 0: push 0x11..0x15 → count_o = 5, full_o = 1, in_rdy_o = 0. A 6th push is held off. Drain gives 0x11..0x15 in order, then empty_o = 1.
- DEPTH=3: 20 words 0x00..0x13, with push every cycle and pop every cycle after the first → all words out in order across multiple pointer wraps, count_o steady at 1.
- Full FIFO with out_rdy_i = 1 and in_val_i = 1 in the same cycle: a pop occurs, no push, and count_o goes DEPTH → DEPTH-1. The next cycle both occur and count_o stays at DEPTH-1.
- Flush with 3 words queued, asserted together with in_val_i = 1 and out_rdy_i = 1: no transfer that cycle. The next cycle count_o = 0, and the following push of 0xAB is the first word popped.
- FALLTHROUGH=1, empty FIFO, in_val_i = 1, in_data_i = 0x5A, out_rdy_i = 1: out_data_o = 0x5A in the same cycle and count_o stays 0. Repeat with out_rdy_i = 0 → count_o = 1 next cycle. AF_LEVEL=2 / AE_LEVEL=1 flags toggle at counts 2 and 1 respectively.

Source files
------------

// File: rtl/fifo_param.sv
// fifo_param: parametrised valid/ready FIFO with occupancy flags, flush and optional fall-through.
module fifo_param #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 4,
  parameter int AF_LEVEL    = DEPTH - 1,
  parameter int AE_LEVEL    = 1,
  parameter bit FALLTHROUGH = 1'b0,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_val_i,
  output logic             in_rdy_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_val_o,
  input  logic             out_rdy_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o
);
  localparam int PW = $clog2(DEPTH);

  if (WIDTH < 1) begin : g_bad_width
    $error("fifo_param: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_param: DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_param: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_param: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rptr, r_wptr;
  logic [CW-1:0]    r_count;
  logic             w_ft, w_push, w_pop, w_bypass, w_wr, w_rd;

  // Fall-through only applies to an empty, non-flushing FIFO.
  assign w_ft       = FALLTHROUGH && (r_count == '0) && !flush_i;
  assign in_rdy_o   = !flush_i && (r_count != CW'(DEPTH));
  assign out_val_o  = w_ft ? in_val_i : (!flush_i && (r_count != '0));
  assign out_data_o = w_ft ? in_data_i : r_mem[r_rptr];
  assign w_push     = in_val_i && in_rdy_o;
  assign w_pop      = out_val_o && out_rdy_i;
  assign w_bypass   = w_ft && w_push && w_pop;
  assign w_wr       = w_push && !w_bypass;
  assign w_rd       = w_pop && !w_bypass;

  assign count_o        = r_count;
  assign full_o         = r_count == CW'(DEPTH);
  assign empty_o        = r_count == '0;
  assign almost_full_o  = r_count >= CW'(AF_LEVEL);
  assign almost_empty_o = r_count <= CW'(AE_LEVEL);

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr] <= in_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (w_rd) r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      r_count <= (w_wr && !w_rd) ? r_count + 1'b1 :
                 (w_rd && !w_wr) ? r_count - 1'b1 : r_count;
    end
  end
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: two FIFO configurations (DEPTH=5 registered, DEPTH=3 fall-through) against a queue model.
module tb_fifo_param;
  logic       clk = 0, rst_n = 0, flush = 0, in_val = 0, out_rdy = 0;
  logic [7:0] in_data = '0;
  logic [1:0] o_in_rdy, o_out_val, o_full, o_empty, o_af, o_ae;
  logic [1:0][7:0] o_data;
  logic [2:0] a_cnt;
  logic [1:0] b_cnt;
  logic [7:0] mq [2][$];
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  fifo_param #(.WIDTH(8), .DEPTH(5), .AE_LEVEL(1), .FALLTHROUGH(1'b0)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_val_i(in_val), .in_rdy_o(o_in_rdy[0]), .in_data_i(in_data),
    .out_val_o(o_out_val[0]), .out_rdy_i(out_rdy), .out_data_o(o_data[0]),
    .count_o(a_cnt), .full_o(o_full[0]), .empty_o(o_empty[0]),
    .almost_full_o(o_af[0]), .almost_empty_o(o_ae[0])
  );

  fifo_param #(.WIDTH(8), .DEPTH(3), .AF_LEVEL(2), .AE_LEVEL(1), .FALLTHROUGH(1'b1)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_val_i(in_val), .in_rdy_o(o_in_rdy[1]), .in_data_i(in_data),
    .out_val_o(o_out_val[1]), .out_rdy_i(out_rdy), .out_data_o(o_data[1]),
    .count_o(b_cnt), .full_o(o_full[1]), .empty_o(o_empty[1]),
    .almost_full_o(o_af[1]), .almost_empty_o(o_ae[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit r, input bit f);
    in_val = v; in_data = d; out_rdy = r; flush = f;
  endtask

  // Check every output of both FIFOs at the negedge, then advance the model on the posedge.
  task automatic cyc();
    bit pu [2], po [2], fb [2];
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      int d, af, cnt;
      bit ft, rdy, ov;
      string p;
      d   = k ? 3 : 5;
      af  = k ? 2 : 4;
      cnt = mq[k].size();
      ft  = (k == 1) && cnt == 0 && !flush;
      rdy = !flush && cnt < d;
      ov  = ft ? in_val : (!flush && cnt > 0);
      p   = k ? "b_" : "a_";
      chk({p, "in_rdy"}, 32'(o_in_rdy[k]), 32'(rdy));
      chk({p, "out_val"}, 32'(o_out_val[k]), 32'(ov));
      chk({p, "count"}, k ? 32'(b_cnt) : 32'(a_cnt), 32'(cnt));
      chk({p, "full"}, 32'(o_full[k]), 32'(cnt == d));
      chk({p, "empty"}, 32'(o_empty[k]), 32'(cnt == 0));
      chk({p, "afull"}, 32'(o_af[k]), 32'(cnt >= af));
      chk({p, "aempty"}, 32'(o_ae[k]), 32'(cnt <= 1));
      if (ov) chk({p, "data"}, 32'(o_data[k]), 32'(ft ? in_data : mq[k][0]));
      pu[k] = in_val && rdy;
      po[k] = ov && out_rdy;
      fb[k] = ft;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (flush) mq[k].delete();
      else if (!(fb[k] && pu[k] && po[k])) begin
        if (po[k]) void'(mq[k].pop_front());
        if (pu[k]) mq[k].push_back(in_data);
      end
    end
    #1;
  endtask

  initial begin
    #12 rst_n = 1;
    @(posedge clk); #1;
    drive(0, 8'h00, 0, 0); cyc(); cyc();
    for (int i = 0; i < 6; i++) begin drive(1, 8'h11 + 8'(i), 0, 0); cyc(); end
    for (int i = 0; i < 6; i++) begin drive(0, 8'h00, 1, 0); cyc(); end
    for (int i = 0; i < 5; i++) begin drive(1, 8'($urandom), 0, 0); cyc(); end
    drive(1, 8'h77, 1, 0); cyc();
    drive(1, 8'h78, 1, 0); cyc();
    for (int i = 0; i < 6; i++) begin drive(0, 8'h00, 1, 0); cyc(); end
    for (int i = 0; i < 3; i++) begin drive(1, 8'h30 + 8'(i), 0, 0); cyc(); end
    drive(1, 8'hCC, 1, 1); cyc();
    drive(1, 8'hAB, 0, 0); cyc();
    drive(0, 8'h00, 1, 0); cyc(); cyc();
    for (int i = 0; i < 20; i++) begin drive(1, 8'(i), i > 0, 0); cyc(); end
    for (int i = 0; i < 4; i++) begin drive(0, 8'h00, 1, 0); cyc(); end
    drive(1, 8'h5A, 1, 0); cyc();
    drive(1, 8'h5A, 0, 0); cyc();
    for (int i = 0; i < 4; i++) begin drive(0, 8'h00, 1, 0); cyc(); end
    for (int i = 0; i < 3; i++) begin drive(1, 8'h40 + 8'(i), 0, 0); cyc(); end
    drive(0, 8'h00, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("rst_a_count", 32'(a_cnt), 32'd0);
    chk("rst_a_out_val", 32'(o_out_val[0]), 32'd0);
    chk("rst_b_count", 32'(b_cnt), 32'd0);
    chk("rst_b_out_val", 32'(o_out_val[1]), 32'd0);
    chk("rst_a_empty", 32'(o_empty[0]), 32'd1);
    mq[0].delete(); mq[1].delete();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    cyc();
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 15) == 0);
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
